// File: rtl/vc_fifo.sv
// vc_fifo: single-clock circular-buffer FIFO with registered read data, registered
// occupancy/threshold flags and a one-cycle error pulse on overflow/underflow.
`default_nettype none

module vc_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = 3,
  parameter int AE_TH  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     pop_delay_vc,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              pop_ok;
  logic              push_ok;
  logic              err_next;
  logic [CW-1:0]     count_next;

  // A push into a full FIFO is legal when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok     = pop_delay_vc && !empty;
    push_ok    = push && (!full || pop_ok);
    err_next   = (push && full && !pop_ok) || (pop_delay_vc && empty);
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_next = count - CW'(1);
  end

  // Storage is not reset; data_out only ever loads from a slot already written.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      error        <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      valid_out    <= pop_ok;
      error        <= err_next;
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_TH));
      almost_empty <= (count_next <= CW'(AE_TH));
    end
  end

endmodule

`default_nettype wire
